// File: rtl/mem_stage.sv
// mem_stage: memory-access pipeline stage between EX/MEM and MEM/WB.
// Drives a req/ack data bus with wait states, steers byte/halfword store lanes,
// extends load data and flags misaligned accesses.
// Optional feature: define MEM_TIMEOUT_EN to abort a WAIT after TIMEOUT cycles
// and report it on bus_err_W. Without it WAIT is unbounded and bus_err_W stays 0.
module mem_stage #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        RegWriteM,
    input  logic        MemtoRegM,
    input  logic        MemWriteM,
    input  logic        MEM_Link,
    input  logic [4:0]  WriteRegM,
    input  logic [31:0] MEM_ALUOut,
    input  logic [31:0] MEM_WriteData,
    input  logic [31:0] MEM_PCPlus4,
    input  logic [31:0] MEM_Instr,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        stall_M,
    output logic        RegWriteW,
    output logic        MemtoRegW,
    output logic        WB_Link,
    output logic [4:0]  WriteRegW,
    output logic [31:0] WB_ALUOut,
    output logic [31:0] WB_ReadData,
    output logic [31:0] WB_PCPlus4,
    output logic [31:0] WB_Instr,
    output logic        misalign_W,
    output logic        bus_err_W
);

    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_SB  = 6'h28;
    localparam logic [5:0] OP_SH  = 6'h29;
    localparam int unsigned CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic [5:0]  opcode;
    logic [1:0]  off;
    logic        acc;
    logic        is_store;
    logic        is_load;
    logic        is_byte;
    logic        is_half;
    logic        is_signed;
    logic        misalign_c;
    logic        timeout_c;
    logic        squash_c;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] rd_ext;

`ifdef MEM_TIMEOUT_EN
    logic [CNT_W-1:0] wait_cnt;
`endif

    // A zero TIMEOUT would make the abort compare underflow.
    if (TIMEOUT == 0) begin : g_timeout_check
        $error("mem_stage: TIMEOUT must be nonzero");
    end

    // Access-size decode and alignment check; a store wins over a load.
    always_comb begin
        opcode     = MEM_Instr[31:26];
        off        = MEM_ALUOut[1:0];
        acc        = MemtoRegM | MemWriteM;
        is_store   = MemWriteM;
        is_load    = MemtoRegM & ~MemWriteM;
        is_byte    = (opcode == OP_LB) | (opcode == OP_LBU) | (opcode == OP_SB);
        is_half    = (opcode == OP_LH) | (opcode == OP_LHU) | (opcode == OP_SH);
        is_signed  = (opcode == OP_LB) | (opcode == OP_LH);
        misalign_c = acc & ((is_half & off[0]) |
                            (~is_byte & ~is_half & (off != 2'b00)));
    end

    // Store lane steering: replicate narrow data, enable only the addressed lanes.
    always_comb begin
        dmem_addr  = {MEM_ALUOut[31:2], 2'b00};
        dmem_wdata = MEM_WriteData;
        dmem_be    = 4'b1111;
        if (is_store) begin
            if (is_byte) begin
                dmem_wdata = {4{MEM_WriteData[7:0]}};
                dmem_be    = 4'(4'b0001 << off);
            end else if (is_half) begin
                dmem_wdata = {2{MEM_WriteData[15:0]}};
                dmem_be    = off[1] ? 4'b1100 : 4'b0011;
            end
        end
    end

    // Load lane extraction and sign/zero extension.
    always_comb begin
        unique case (off)
            2'd0:    byte_sel = dmem_rdata[7:0];
            2'd1:    byte_sel = dmem_rdata[15:8];
            2'd2:    byte_sel = dmem_rdata[23:16];
            default: byte_sel = dmem_rdata[31:24];
        endcase
        half_sel = off[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        if (is_byte) begin
            rd_ext = is_signed ? {{24{byte_sel[7]}}, byte_sel} : {24'd0, byte_sel};
        end else if (is_half) begin
            rd_ext = is_signed ? {{16{half_sel[15]}}, half_sel} : {16'd0, half_sel};
        end else begin
            rd_ext = dmem_rdata;
        end
    end

    // Next-state and bus handshake; reset kills the request immediately.
    always_comb begin
        state_nxt = state;
        dmem_req  = 1'b0;
        stall_M   = 1'b0;
        timeout_c = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (acc && !misalign_c) begin
                    dmem_req = 1'b1;
                    if (!dmem_ack) begin
                        stall_M   = 1'b1;
                        state_nxt = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                dmem_req = 1'b1;
                if (dmem_ack) begin
                    state_nxt = S_IDLE;
`ifdef MEM_TIMEOUT_EN
                end else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
                    timeout_c = 1'b1;
                    state_nxt = S_IDLE;
`endif
                end else begin
                    stall_M = 1'b1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
        if (!rst_n) begin
            dmem_req = 1'b0;
            stall_M  = 1'b0;
        end
        dmem_we  = dmem_req & MemWriteM;
        squash_c = misalign_c | timeout_c;
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

`ifdef MEM_TIMEOUT_EN
    // WAIT-cycle counter, cleared whenever the FSM is idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else if (state == S_IDLE) begin
            wait_cnt <= '0;
        end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
        end
    end
`endif

    // MEM/WB register: bubble while stalled, squashed write on misalign/timeout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            RegWriteW   <= 1'b0;
            MemtoRegW   <= 1'b0;
            WB_Link     <= 1'b0;
            WriteRegW   <= 5'd0;
            WB_ALUOut   <= 32'd0;
            WB_ReadData <= 32'd0;
            WB_PCPlus4  <= 32'd0;
            WB_Instr    <= 32'd0;
            misalign_W  <= 1'b0;
            bus_err_W   <= 1'b0;
        end else if (stall_M) begin
            RegWriteW  <= 1'b0;
            MemtoRegW  <= 1'b0;
            WB_Link    <= 1'b0;
            misalign_W <= 1'b0;
            bus_err_W  <= 1'b0;
        end else begin
            RegWriteW   <= RegWriteM & ~squash_c;
            MemtoRegW   <= is_load & ~squash_c;
            WB_Link     <= MEM_Link & ~squash_c;
            WriteRegW   <= WriteRegM;
            WB_ALUOut   <= MEM_ALUOut;
            WB_ReadData <= (is_load && !squash_c) ? rd_ext : 32'd0;
            WB_PCPlus4  <= MEM_PCPlus4;
            WB_Instr    <= MEM_Instr;
            misalign_W  <= misalign_c;
            bus_err_W   <= timeout_c;
        end
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage directly downstream of the EX/MEM pipeline register; consumes its M-side outputs.
- Performs load/store on the data-memory bus with a req/ack handshake, including wait states.
- Handles byte/halfword lane steering and load sign/zero extension, and detects misaligned accesses.
- Asserts stall_M while an access is outstanding; registers results into MEM/WB outputs for the writeback stage.

Parameters:
- TIMEOUT, 255: max WAIT cycles before abort (used only with MEM_TIMEOUT_EN).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- RegWriteM, MemtoRegM, MemWriteM, MEM_Link  in  1 each  control bits from EX/MEM.
- WriteRegM  in  5  destination register.
- MEM_ALUOut  in  32  effective address / ALU result.
- MEM_WriteData  in  32  store data.
- MEM_PCPlus4, MEM_Instr  in  32 each  PC+4 and instruction word.
- dmem_req  out  1  bus request.
- dmem_we  out  1  1 = store.
- dmem_addr  out  32  word address, {MEM_ALUOut[31:2],2'b00}.
- dmem_wdata  out  32  lane-steered store data.
- dmem_be  out  4  byte enables.
- dmem_ack  in  1  bus completion.
- dmem_rdata  in  32  load data, valid with ack.
- stall_M  out  1  upstream must hold EX/MEM contents.
- RegWriteW, MemtoRegW, WB_Link  out  1 each  registered control.
- WriteRegW  out  5  registered destination register.
- WB_ALUOut, WB_ReadData, WB_PCPlus4, WB_Instr  out  32 each  registered data.
- misalign_W  out  1  misaligned access flag.
- bus_err_W  out  1  timeout flag (0 without macro).

Behaviour:
- Access condition: acc = MemtoRegM | MemWriteM. If both are set, the store wins and no read data is captured.
- Opcode = MEM_Instr[31:26]:
  - Loads: lb 0x20, lh 0x21, lw 0x23, lbu 0x24, lhu 0x25.
  - Stores: sb 0x28, sh 0x29, sw 0x2B.
  - Any other opcode with acc set is treated as a word access.
- Misalignment: word with ALUOut[1:0]!=0, or half with ALUOut[0]!=0.
  - No request is issued and there is no stall.
  - Next edge: WB regs load with RegWriteW=0, MemtoRegW=0, misalign_W=1.
- Store lanes (little-endian, lane0 = bits[7:0]):
  - sb: byte replicated x4, be = 1<<ALUOut[1:0].
  - sh: half replicated x2, be = 0011 or 1100 by ALUOut[1].
  - sw: be = 1111.
- Loads: be = 1111. Extract the byte/half lane from dmem_rdata by ALUOut[1:0]; lb/lh sign-extend, lbu/lhu zero-extend.
- FSM states IDLE and WAIT. dmem_req, dmem_we, addr, wdata and be are combinational from the M inputs.
- IDLE:
  - acc and aligned: dmem_req=1. If dmem_ack is high the same cycle, there is no stall and the instruction completes at this edge. Otherwise stall_M=1 and the FSM goes to WAIT.
  - No acc: passthrough, WB regs capture the M inputs with 1-cycle latency.
- WAIT:
  - dmem_req and stall_M held at 1. All bus outputs stay stable because upstream holds.
  - On dmem_ack: WB regs capture, WB_ReadData = extended data, stall_M drops combinationally, FSM returns to IDLE.
- While stall_M=1 at a clock edge, WB regs load a bubble: RegWriteW=0, MemtoRegW=0, flags 0; data fields are don't-care but held.
- Reset (asynchronous, any state including mid-WAIT):
  - FSM goes to IDLE and all outputs/regs go to 0.
  - dmem_req drops immediately; an ack arriving after reset is ignored.
- dmem_ack while IDLE with no request: ignored.
- WB_ReadData for non-loads: 0.

Optional Feature:
- Macro MEM_TIMEOUT_EN.
- Defined:
  - An 8-bit+ counter increments each WAIT cycle.
  - On reaching TIMEOUT without ack: abort to IDLE and load WB with RegWriteW=0, MemtoRegW=0, bus_err_W=1 for one cycle. stall_M drops that cycle.
  - The counter clears on entering WAIT.
- Undefined: no counter, WAIT is unbounded, bus_err_W tied 0.

Test Plan:
- lw ALUOut=0x104, ack same cycle, rdata=0xDEADBEEF -> no stall; next edge WB_ReadData=0xDEADBEEF, RegWriteW=1.
- lb ALUOut=0x103, ack after 3 wait cycles, rdata=0x80112233 -> stall_M high 3 cycles with WB bubbles; then WB_ReadData=0xFFFFFF80. Repeat with lbu -> 0x00000080.
- sh ALUOut=0x202, data=0x0000ABCD -> dmem_we=1, dmem_be=1100, dmem_wdata=0xABCDABCD, dmem_addr=0x200.
- lw ALUOut=0x106 -> dmem_req=0, stall_M=0; next edge misalign_W=1, RegWriteW=0.
- Reset asserted in WAIT, then ack pulses -> dmem_req=0 immediately, all WB outputs 0, FSM in IDLE, ack ignored.
- With MEM_TIMEOUT_EN, TIMEOUT=4, no ack -> stall 4 cycles, then bus_err_W=1 for one cycle, RegWriteW=0.
